// File: rtl/wisc_pkg.sv
// Shared WISC encodings: opcodes, branch condition codes, flag bit positions,
// LLB/LHB merge modes and the ID/EX control bundle.
package wisc_pkg;

    localparam logic [3:0] OP_ADD    = 4'h0;
    localparam logic [3:0] OP_SUB    = 4'h1;
    localparam logic [3:0] OP_XOR    = 4'h2;
    localparam logic [3:0] OP_RED    = 4'h3;
    localparam logic [3:0] OP_SLL    = 4'h4;
    localparam logic [3:0] OP_SRA    = 4'h5;
    localparam logic [3:0] OP_ROR    = 4'h6;
    localparam logic [3:0] OP_PADDSB = 4'h7;
    localparam logic [3:0] OP_LW     = 4'h8;
    localparam logic [3:0] OP_SW     = 4'h9;
    localparam logic [3:0] OP_LLB    = 4'hA;
    localparam logic [3:0] OP_LHB    = 4'hB;
    localparam logic [3:0] OP_B      = 4'hC;
    localparam logic [3:0] OP_BR     = 4'hD;
    localparam logic [3:0] OP_PCS    = 4'hE;
    localparam logic [3:0] OP_HLT    = 4'hF;

    localparam logic [2:0] CC_NE = 3'b000;
    localparam logic [2:0] CC_EQ = 3'b001;
    localparam logic [2:0] CC_GT = 3'b010;
    localparam logic [2:0] CC_LT = 3'b011;
    localparam logic [2:0] CC_GE = 3'b100;
    localparam logic [2:0] CC_LE = 3'b101;
    localparam logic [2:0] CC_OV = 3'b110;
    localparam logic [2:0] CC_AL = 3'b111;

    localparam int FLAG_Z = 2;
    localparam int FLAG_V = 1;
    localparam int FLAG_N = 0;

    localparam logic [1:0] LB_NONE = 2'b00;
    localparam logic [1:0] LB_LLB  = 2'b01;
    localparam logic [1:0] LB_LHB  = 2'b10;

    typedef struct packed {
        logic [3:0]  alu_op;
        logic [3:0]  rd;
        logic [3:0]  rs;
        logic [3:0]  rt;
        logic [15:0] imm;
        logic        use_imm;
        logic        reg_we;
        logic        mem_re;
        logic        mem_we;
        logic [1:0]  lb_mode;
        logic        is_branch;
        logic        br_reg;
        logic        pcs;
        logic        halt;
        logic        upd_z;   // instruction writes Z
        logic        upd_vn;  // instruction also writes V and N
    } idex_ctrl_t;

    function automatic logic cond_met(input logic [2:0] ccc, input logic [2:0] flags);
        logic z, v, n;
        z = flags[FLAG_Z];
        v = flags[FLAG_V];
        n = flags[FLAG_N];
        case (ccc)
            CC_NE:   cond_met = !z;
            CC_EQ:   cond_met = z;
            CC_GT:   cond_met = !z && !n;
            CC_LT:   cond_met = n;
            CC_GE:   cond_met = z || (!z && !n);
            CC_LE:   cond_met = n || z;
            CC_OV:   cond_met = v;
            default: cond_met = 1'b1;
        endcase
    endfunction

endpackage

// File: rtl/insn_decode.sv
// Combinational instruction decoder: maps a 16-bit WISC instruction to the
// ID/EX control bundle.
module insn_decode
    import wisc_pkg::*;
(
    input  logic [15:0] instr,
    output idex_ctrl_t  ctrl
);

    logic [3:0] op;
    assign op = instr[15:12];

    always_comb begin
        ctrl    = '0;
        ctrl.rd = instr[11:8];
        ctrl.rs = instr[7:4];
        ctrl.rt = instr[3:0];
        case (op)
            OP_ADD, OP_SUB: begin
                ctrl.alu_op = op;
                ctrl.reg_we = 1'b1;
                ctrl.upd_z  = 1'b1;
                ctrl.upd_vn = 1'b1;
            end
            OP_XOR: begin
                ctrl.alu_op = op;
                ctrl.reg_we = 1'b1;
                ctrl.upd_z  = 1'b1;
            end
            OP_RED, OP_PADDSB: begin
                ctrl.alu_op = op;
                ctrl.reg_we = 1'b1;
            end
            OP_SLL, OP_SRA, OP_ROR: begin
                ctrl.alu_op  = op;
                ctrl.reg_we  = 1'b1;
                ctrl.use_imm = 1'b1;
                ctrl.imm     = {12'h000, instr[3:0]};
                ctrl.upd_z   = 1'b1;
            end
            OP_LW: begin
                ctrl.alu_op  = OP_ADD;
                ctrl.use_imm = 1'b1;
                ctrl.imm     = {{11{instr[3]}}, instr[3:0], 1'b0};
                ctrl.mem_re  = 1'b1;
                ctrl.reg_we  = 1'b1;
            end
            OP_SW: begin
                // Store data register lives in the rd field; route it onto rt.
                ctrl.alu_op  = OP_ADD;
                ctrl.use_imm = 1'b1;
                ctrl.imm     = {{11{instr[3]}}, instr[3:0], 1'b0};
                ctrl.mem_we  = 1'b1;
                ctrl.rt      = instr[11:8];
            end
            OP_LLB: begin
                ctrl.alu_op  = OP_ADD;
                ctrl.use_imm = 1'b1;
                ctrl.imm     = {8'h00, instr[7:0]};
                ctrl.lb_mode = LB_LLB;
                ctrl.reg_we  = 1'b1;
            end
            OP_LHB: begin
                ctrl.alu_op  = OP_ADD;
                ctrl.use_imm = 1'b1;
                ctrl.imm     = {instr[7:0], 8'h00};
                ctrl.lb_mode = LB_LHB;
                ctrl.reg_we  = 1'b1;
            end
            OP_B: begin
                ctrl.is_branch = 1'b1;
                ctrl.imm       = {{6{instr[8]}}, instr[8:0], 1'b0};
            end
            OP_BR: begin
                ctrl.is_branch = 1'b1;
                ctrl.br_reg    = 1'b1;
            end
            OP_PCS: begin
                ctrl.pcs    = 1'b1;
                ctrl.reg_we = 1'b1;
            end
            OP_HLT: begin
                ctrl.halt = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/id_ex_ctrl.sv
// WISC decode + ID/EX pipeline register, Z/V/N flag register, sticky halt
// and branch-condition resolution for the instruction in EX.
module id_ex_ctrl
    import wisc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        if_valid,
    input  logic [15:0] if_instr,
    input  logic        stall,
    input  logic        flush,
    input  logic [15:0] alu_out,
    input  logic        alu_v,
    output logic        ex_valid,
    output logic [3:0]  ex_alu_op,
    output logic [3:0]  ex_rd,
    output logic [3:0]  ex_rs,
    output logic [3:0]  ex_rt,
    output logic [15:0] ex_imm,
    output logic        ex_use_imm,
    output logic        ex_reg_we,
    output logic        ex_mem_re,
    output logic        ex_mem_we,
    output logic [1:0]  ex_lb_mode,
    output logic        ex_is_branch,
    output logic        ex_br_reg,
    output logic        ex_pcs,
    output logic        ex_halt,
    output logic [2:0]  flags,
    output logic        br_taken
);

    idex_ctrl_t dec_ctrl;
    idex_ctrl_t ctrl_d, ctrl_q;
    logic       ex_valid_d, ex_valid_q;
    logic [2:0] flags_d, flags_q;
    logic       halted_d, halted_q;

    insn_decode u_decode (
        .instr (if_instr),
        .ctrl  (dec_ctrl)
    );

    always_comb begin
        ctrl_d     = ctrl_q;
        ex_valid_d = ex_valid_q;
        flags_d    = flags_q;
        // A HLT sitting in EX blocks the instruction arriving on the same edge.
        halted_d   = halted_q | (ex_valid_q & ctrl_q.halt);

        if (ex_valid_q && !stall) begin
            if (ctrl_q.upd_z) begin
                flags_d[FLAG_Z] = (alu_out == 16'h0000);
            end
            if (ctrl_q.upd_vn) begin
                flags_d[FLAG_V] = alu_v;
                flags_d[FLAG_N] = alu_out[15];
            end
        end

        if (flush) begin
            ex_valid_d = 1'b0;
        end else if (!stall) begin
            ex_valid_d = if_valid & ~halted_d;
            ctrl_d     = dec_ctrl;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ctrl_q     <= '0;
            ex_valid_q <= 1'b0;
            flags_q    <= 3'b000;
            halted_q   <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            ex_valid_q <= ex_valid_d;
            flags_q    <= flags_d;
            halted_q   <= halted_d;
        end
    end

    assign ex_valid     = ex_valid_q;
    assign ex_alu_op    = ctrl_q.alu_op;
    assign ex_rd        = ctrl_q.rd;
    assign ex_rs        = ctrl_q.rs;
    assign ex_rt        = ctrl_q.rt;
    assign ex_imm       = ctrl_q.imm;
    assign ex_use_imm   = ctrl_q.use_imm;
    assign ex_lb_mode   = ctrl_q.lb_mode;
    // Side-effecting controls are forced low for bubbles.
    assign ex_reg_we    = ex_valid_q & ctrl_q.reg_we;
    assign ex_mem_re    = ex_valid_q & ctrl_q.mem_re;
    assign ex_mem_we    = ex_valid_q & ctrl_q.mem_we;
    assign ex_is_branch = ex_valid_q & ctrl_q.is_branch;
    assign ex_br_reg    = ex_valid_q & ctrl_q.br_reg;
    assign ex_pcs       = ex_valid_q & ctrl_q.pcs;
    assign ex_halt      = ex_valid_q & ctrl_q.halt;
    assign flags        = flags_q;

    // Condition code is instr[11:9], i.e. the top three bits of the rd field.
    assign br_taken = ex_valid_q & ctrl_q.is_branch & cond_met(ctrl_q.rd[3:1], flags_q);

endmodule

// File: tb/tb_id_ex_ctrl.sv
// Self-checking bench for id_ex_ctrl: directed scenarios plus random stimulus
// against an instruction-level reference model.
module tb_id_ex_ctrl;

    logic        clk = 1'b0;
    logic        rst, if_valid, stall, flush, alu_v;
    logic [15:0] if_instr, alu_out;
    logic        ex_valid, ex_use_imm, ex_reg_we, ex_mem_re, ex_mem_we;
    logic        ex_is_branch, ex_br_reg, ex_pcs, ex_halt, br_taken;
    logic [3:0]  ex_alu_op, ex_rd, ex_rs, ex_rt;
    logic [15:0] ex_imm;
    logic [1:0]  ex_lb_mode;
    logic [2:0]  flags;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model state: the instruction word in EX plus architectural bits.
    logic        m_valid, m_halted, m_z, m_v, m_n;
    logic [15:0] m_instr;

    always #5 clk = ~clk;

    id_ex_ctrl dut (
        .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr),
        .stall(stall), .flush(flush), .alu_out(alu_out), .alu_v(alu_v),
        .ex_valid(ex_valid), .ex_alu_op(ex_alu_op), .ex_rd(ex_rd), .ex_rs(ex_rs),
        .ex_rt(ex_rt), .ex_imm(ex_imm), .ex_use_imm(ex_use_imm),
        .ex_reg_we(ex_reg_we), .ex_mem_re(ex_mem_re), .ex_mem_we(ex_mem_we),
        .ex_lb_mode(ex_lb_mode), .ex_is_branch(ex_is_branch), .ex_br_reg(ex_br_reg),
        .ex_pcs(ex_pcs), .ex_halt(ex_halt), .flags(flags), .br_taken(br_taken)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    endtask

    function automatic logic exp_cond(input logic [2:0] ccc);
        case (ccc)
            3'd0: return !m_z;
            3'd1: return m_z;
            3'd2: return !m_z && !m_n;
            3'd3: return m_n;
            3'd4: return m_z || (!m_z && !m_n);
            3'd5: return m_n || m_z;
            3'd6: return m_v;
            default: return 1'b1;
        endcase
    endfunction

    task automatic compare_all();
        int          op;
        logic [15:0] i, e_imm, s4, s9;
        i     = m_instr;
        op    = int'(i[15:12]);
        s4    = {{12{i[3]}}, i[3:0]};
        s9    = {{7{i[8]}}, i[8:0]};
        e_imm = 16'h0;
        if (op >= 4 && op <= 6) e_imm = {12'h0, i[3:0]};
        else if (op == 8 || op == 9) e_imm = s4 * 16'd2;
        else if (op == 10) e_imm = {8'h00, i[7:0]};
        else if (op == 11) e_imm = {i[7:0], 8'h00};
        else if (op == 12) e_imm = s9 * 16'd2;

        check_eq("ex_valid", ex_valid, m_valid);
        check_eq("flags", flags, {m_z, m_v, m_n});
        check_eq("reg_we", ex_reg_we, m_valid && (op <= 8 || op == 10 || op == 11 || op == 14));
        check_eq("mem_re", ex_mem_re, m_valid && op == 8);
        check_eq("mem_we", ex_mem_we, m_valid && op == 9);
        check_eq("is_branch", ex_is_branch, m_valid && (op == 12 || op == 13));
        check_eq("br_reg", ex_br_reg, m_valid && op == 13);
        check_eq("pcs", ex_pcs, m_valid && op == 14);
        check_eq("halt", ex_halt, m_valid && op == 15);
        check_eq("br_taken", br_taken, m_valid && (op == 12 || op == 13) && exp_cond(i[11:9]));
        if (m_valid) begin
            check_eq("alu_op", ex_alu_op, (op < 8) ? op : 0);
            check_eq("rd", ex_rd, i[11:8]);
            check_eq("rs", ex_rs, i[7:4]);
            check_eq("rt", ex_rt, (op == 9) ? i[11:8] : i[3:0]);
            check_eq("imm", ex_imm, e_imm);
            check_eq("use_imm", ex_use_imm, (op >= 4 && op <= 6) || (op >= 8 && op <= 11));
            check_eq("lb_mode", ex_lb_mode, (op == 10) ? 2'b01 : (op == 11) ? 2'b10 : 2'b00);
        end
    endtask

    task automatic step(input logic r, input logic iv, input logic [15:0] ins,
                        input logic st, input logic fl, input logic [15:0] ao, input logic av);
        int   op;
        logic h;
        rst = r; if_valid = iv; if_instr = ins; stall = st; flush = fl;
        alu_out = ao; alu_v = av;
        if (r) begin
            m_valid = 0; m_halted = 0; m_instr = 16'h0; m_z = 0; m_v = 0; m_n = 0;
        end else begin
            op = int'(m_instr[15:12]);
            if (m_valid && !st) begin
                if (op == 0 || op == 1) begin
                    m_z = (ao == 16'h0); m_v = av; m_n = ao[15];
                end else if (op == 2 || op == 4 || op == 5 || op == 6) begin
                    m_z = (ao == 16'h0);
                end
            end
            h = m_halted || (m_valid && op == 15);
            if (fl) m_valid = 0;
            else if (!st) begin
                m_valid = iv && !h;
                m_instr = ins;
            end
            m_halted = h;
        end
        @(posedge clk);
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        logic [15:0] ins;
        rst = 1; if_valid = 0; if_instr = 0; stall = 0; flush = 0; alu_out = 0; alu_v = 0;

        step(1, 1, 16'h0123, 0, 0, 16'h0, 0);
        check_eq("rst_valid", ex_valid, 0);
        check_eq("rst_fields", {ex_alu_op, ex_rd, ex_rs, ex_rt}, 0);
        check_eq("rst_imm", ex_imm, 0);
        check_eq("rst_flags", flags, 0);
        check_eq("rst_ctl", {ex_use_imm, ex_lb_mode, ex_reg_we, ex_mem_re, ex_mem_we,
                             ex_is_branch, ex_br_reg, ex_pcs, ex_halt, br_taken}, 0);

        step(0, 1, 16'h0123, 0, 0, 16'h1234, 0);          // ADD R1,R2,R3 into EX
        check_eq("add_op", ex_alu_op, 4'h0);
        check_eq("add_we", ex_reg_we, 1);
        step(0, 1, 16'h812F, 0, 0, 16'h0000, 1);          // ADD result 0, V=1; LW into EX
        check_eq("add_flags", flags, 3'b110);
        check_eq("lw_imm", ex_imm, 16'hFFFE);
        check_eq("lw_mem_re", ex_mem_re, 1);
        step(0, 1, 16'hB3A5, 0, 0, 16'hFFFF, 0);          // LHB
        check_eq("lhb_imm", ex_imm, 16'hA500);
        check_eq("lhb_mode", ex_lb_mode, 2'b10);
        check_eq("lw_noflag", flags, 3'b110);
        step(0, 1, 16'hC205, 0, 0, 16'hFFFF, 0);          // B EQ with Z=1
        check_eq("b_eq_z", br_taken, 1);
        step(0, 1, 16'hC010, 0, 0, 16'h0000, 0);          // B NE with Z=1
        check_eq("b_ne_z", br_taken, 0);
        step(0, 1, 16'h1456, 0, 0, 16'h0000, 0);          // SUB
        step(0, 1, 16'hCA00, 0, 0, 16'hFFFF, 0);          // SUB -> 0xFFFF; B LE
        check_eq("sub_flags", flags, 3'b001);
        check_eq("b_le_n", br_taken, 1);

        step(0, 1, 16'h0111, 0, 0, 16'h0000, 0);          // ADD into EX
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 16'h2ABC, 1, 0, 16'h0000, 1);
            check_eq("stall_op", {ex_valid, ex_alu_op, ex_rd}, {1'b1, 4'h0, 4'h1});
            check_eq("stall_flags", flags, 3'b001);
        end
        step(0, 1, 16'h2ABC, 1, 1, 16'h0000, 1);
        check_eq("stflush_valid", ex_valid, 0);
        check_eq("stflush_flags", flags, 3'b001);

        step(0, 1, 16'hF000, 0, 0, 16'h0, 0);             // HLT
        check_eq("hlt_in_ex", ex_halt, 1);
        step(0, 1, 16'h0123, 0, 0, 16'h0, 0);
        check_eq("hlt_block", {ex_valid, ex_halt}, 2'b00);
        step(0, 1, 16'h0123, 0, 0, 16'h0, 0);
        check_eq("hlt_sticky", ex_valid, 0);
        step(1, 1, 16'h0123, 0, 0, 16'h0, 0);
        check_eq("rst2_all", {ex_valid, flags, ex_reg_we, ex_halt}, 0);
        step(0, 1, 16'h0123, 0, 0, 16'h0, 0);
        check_eq("post_rst_add", {ex_valid, ex_reg_we}, 2'b11);

        for (int k = 0; k < 3000; k++) begin
            ins = 16'($urandom);
            if (ins[15:12] == 4'hF && $urandom_range(0, 3) != 0) ins[15:12] = 4'h0;
            step($urandom_range(0, 99) < 3,
                 $urandom_range(0, 3) != 0,
                 ins,
                 $urandom_range(0, 4) == 0,
                 $urandom_range(0, 9) == 0,
                 ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom),
                 1'($urandom));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
